cpu_run_ctrl: RTL and testbench

//  Run-control sequencer for the SAP-style CPU core. It gates the CPU's T-state advance with a

---
 rtl/cpu_run_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_run_ctrl: run/stop/step sequencer gating the CPU T-state clock enable.
// Rev 1.0. Optional breakpoint compare built when CPU_BREAKPOINT_EN is defined.
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int PC_W        = 4,
  parameter int STAGE_W     = 3,
  parameter int HALT_STAGE  = 6,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               btn_run,
  input  logic               btn_stop,
  input  logic               btn_step_t,
  input  logic               btn_step_i,
  input  logic [STAGE_W-1:0] cpu_stage,
  input  logic [PC_W-1:0]    cpu_pc,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  output logic               cpu_ce,
  output logic [2:0]         mode,
  output logic               running,
  output logic               halted,
  output logic               bp_hit,
  output logic [CNT_W-1:0]   instr_cnt
);

  typedef enum logic [2:0] {
    ST_STOPPED = 3'd0,
    ST_RUN     = 3'd1,
    ST_STEP_T  = 3'd2,
    ST_STEP_I  = 3'd3,
    ST_HALTED  = 3'd4
  } state_t;

  localparam int CMD_STOP   = 0;
  localparam int CMD_STEP_T = 1;
  localparam int CMD_STEP_I = 2;
  localparam int CMD_RUN    = 3;

  state_t                            state_q, state_d;
  logic                              ce_q, ce_d;
  logic                              ce_seen_q;
  logic                              issued_q, issued_d;
  logic                              bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0]                  cnt_q;
  logic [SYNC_STAGES-1:0][3:0]       sync_q;
  logic [3:0]                        prev_q;
  logic [3:0]                        cmd_q;
  logic [3:0]                        btn_w;
  logic                              retire_w;
  logic                              halt_w;
  logic                              active_w;
  logic                              bp_match_w;

  assign btn_w = {btn_run, btn_step_i, btn_step_t, btn_stop};

  // Synchroniser chain followed by a registered rising-edge pulse per command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
      cmd_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_w};
      prev_q <= sync_q[SYNC_STAGES-1];
      cmd_q  <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign active_w = (state_q == ST_RUN) || (state_q == ST_STEP_T) || (state_q == ST_STEP_I);
  assign retire_w = ce_seen_q && (cpu_stage == '0);
  assign halt_w   = active_w && (cpu_stage == STAGE_W'(HALT_STAGE));

`ifdef CPU_BREAKPOINT_EN
  assign bp_match_w = retire_w && bp_en && (cpu_pc == bp_addr);
`else
  logic unused_bp_w;
  assign unused_bp_w = ^{cpu_pc, bp_en, bp_addr};
  assign bp_match_w  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ce_d     = 1'b0;
    bp_hit_d = 1'b0;
    issued_d = issued_q;
    if (halt_w) begin
      state_d = ST_HALTED;
    end else begin
      case (state_q)
        ST_STOPPED: begin
          if (cmd_q[CMD_STOP]) begin
            state_d = ST_STOPPED;
          end else if (cmd_q[CMD_STEP_T]) begin
            state_d = ST_STEP_T;
          end else if (cmd_q[CMD_STEP_I]) begin
            state_d  = ST_STEP_I;
            issued_d = 1'b0;
          end else if (cmd_q[CMD_RUN]) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (cmd_q[CMD_STOP]) begin
            state_d = ST_STOPPED;
          end else if (bp_match_w) begin
            state_d  = ST_STOPPED;
            bp_hit_d = 1'b1;
          end else begin
            ce_d = tick;
          end
        end
        ST_STEP_T: begin
          if (cmd_q[CMD_STOP]) begin
            state_d = ST_STOPPED;
          end else if (tick) begin
            ce_d    = 1'b1;
            state_d = ST_STOPPED;
          end
        end
        ST_STEP_I: begin
          // A retire only ends the step once this step has advanced the CPU.
          if (cmd_q[CMD_STOP]) begin
            state_d = ST_STOPPED;
          end else if (retire_w && issued_q) begin
            state_d = ST_STOPPED;
          end else if (tick) begin
            ce_d     = 1'b1;
            issued_d = 1'b1;
          end
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STOPPED;
      ce_q      <= 1'b0;
      ce_seen_q <= 1'b0;
      issued_q  <= 1'b0;
      bp_hit_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ce_q      <= ce_d;
      ce_seen_q <= ce_q;
      issued_q  <= issued_d;
      bp_hit_q  <= bp_hit_d;
      if (retire_w && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign cpu_ce    = ce_q;
  assign mode      = state_q;
  assign running   = active_w;
  assign halted    = (state_q == ST_HALTED);
  assign bp_hit    = bp_hit_q;
  assign instr_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl: directed bench with a 5-stage CPU stub and a reference model.
// Rev 1.0. Breakpoint expectations follow CPU_BREAKPOINT_EN.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

  localparam int CNT_W    = 4;
  localparam int SYNC     = 2;
  localparam int HALT     = 6;
  localparam int TICK_DIV = 8;
  localparam int CNT_MAX  = 15;

  localparam logic [3:0] B_STOP   = 4'b0001;
  localparam logic [3:0] B_STEP_T = 4'b0010;
  localparam logic [3:0] B_STEP_I = 4'b0100;
  localparam logic [3:0] B_RUN    = 4'b1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0;
  logic             btn_run = 1'b0, btn_stop = 1'b0, btn_step_t = 1'b0, btn_step_i = 1'b0;
  logic             bp_en = 1'b0;
  logic [3:0]       bp_addr = 4'd4;
  logic [2:0]       cpu_stage;
  logic [3:0]       cpu_pc;
  logic             cpu_ce, running, halted, bp_hit;
  logic [2:0]       mode;
  logic [CNT_W-1:0] instr_cnt;

  int checks = 0;
  int errors = 0;
  int ce_count = 0;
  int bp_count = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .PC_W(4), .STAGE_W(3), .HALT_STAGE(HALT), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .btn_run(btn_run), .btn_stop(btn_stop), .btn_step_t(btn_step_t), .btn_step_i(btn_step_i),
    .cpu_stage(cpu_stage), .cpu_pc(cpu_pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .cpu_ce(cpu_ce), .mode(mode), .running(running), .halted(halted),
    .bp_hit(bp_hit), .instr_cnt(instr_cnt)
  );

  // CPU stub: five T-states, optional early jump back to stage 0, forced halt.
  logic cpu_retired;
  logic jump_en = 1'b0;
  logic halt_req = 1'b0;
  always @(posedge clk or negedge rst_n) begin : cpu_blk
    logic [2:0] nxt;
    if (!rst_n) begin
      cpu_stage   <= '0;
      cpu_pc      <= '0;
      cpu_retired <= 1'b0;
    end else if (halt_req || cpu_stage == 3'(HALT)) begin
      cpu_stage   <= 3'(HALT);
      cpu_retired <= 1'b0;
    end else if (cpu_ce) begin
      nxt = (cpu_stage == 3'd4 || (jump_en && cpu_stage == 3'd2)) ? 3'd0 : cpu_stage + 3'd1;
      cpu_stage   <= nxt;
      cpu_retired <= (nxt == 3'd0);
      if (nxt == 3'd0) cpu_pc <= cpu_pc + 4'd1;
    end else begin
      cpu_retired <= 1'b0;
    end
  end

  // Reference model: commands appear SYNC+1 cycles after a pin edge; mode rules as
  // written for each state, with halt taking precedence over everything.
  int            m_mode, m_cnt;
  logic          m_ce, m_bp, m_issued;
  logic [SYNC+1:0] m_hist [4];
  always @(posedge clk or negedge rst_n) begin : model_blk
    logic [3:0] pins, cmd;
    int         nm;
    logic       nce, nbp, niss, halt_now;
    if (!rst_n) begin
      m_mode <= 0; m_cnt <= 0; m_ce <= 1'b0; m_bp <= 1'b0; m_issued <= 1'b0;
      for (int b = 0; b < 4; b++) m_hist[b] <= '0;
    end else begin
      pins = {btn_run, btn_step_i, btn_step_t, btn_stop};
      for (int b = 0; b < 4; b++) begin
        cmd[b] = m_hist[b][SYNC] & ~m_hist[b][SYNC+1];
        m_hist[b] <= {m_hist[b][SYNC:0], pins[b]};
      end
      nm = m_mode; nce = 1'b0; nbp = 1'b0; niss = m_issued;
      halt_now = (m_mode >= 1 && m_mode <= 3) && (cpu_stage == 3'(HALT));
      if (halt_now) nm = 4;
      else if (m_mode == 0) begin
        if (cmd[0]) nm = 0;
        else if (cmd[1]) nm = 2;
        else if (cmd[2]) begin nm = 3; niss = 1'b0; end
        else if (cmd[3]) nm = 1;
      end else if (m_mode == 1) begin
        if (cmd[0]) nm = 0;
`ifdef CPU_BREAKPOINT_EN
        else if (cpu_retired && bp_en && cpu_pc == bp_addr) begin nm = 0; nbp = 1'b1; end
`endif
        else nce = tick;
      end else if (m_mode == 2) begin
        if (cmd[0]) nm = 0;
        else if (tick) begin nce = 1'b1; nm = 0; end
      end else if (m_mode == 3) begin
        if (cmd[0]) nm = 0;
        else if (cpu_retired && m_issued) nm = 0;
        else if (tick) begin nce = 1'b1; niss = 1'b1; end
      end
      m_mode <= nm; m_ce <= nce; m_bp <= nbp; m_issued <= niss;
      if (cpu_retired && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ce", 32'(cpu_ce), 32'(m_ce));
      chk("mode", 32'(mode), 32'(m_mode));
      chk("instr_cnt", 32'(instr_cnt), 32'(m_cnt));
      chk("bp_hit", 32'(bp_hit), 32'(m_bp));
      chk("running", 32'(running), 32'(m_mode >= 1 && m_mode <= 3));
      chk("halted", 32'(halted), 32'(m_mode == 4));
      if (cpu_ce) ce_count++;
      if (bp_hit) bp_count++;
    end
  end

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      #1;
      tick = (div == TICK_DIV - 1);
      div = (div + 1) % TICK_DIV;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] which);
    {btn_run, btn_step_i, btn_step_t, btn_stop} = which;
    cyc(4);
    {btn_run, btn_step_i, btn_step_t, btn_stop} = 4'b0000;
    cyc(2);
  endtask

  task automatic wait_ce(input int target, input int budget);
    int n;
    n = 0;
    while (ce_count < target && n < budget) begin
      cyc(1);
      n++;
    end
    chk("wait_ce", 32'(ce_count >= target), 32'd1);
  endtask

  int base, base2, bpb, n;

  initial begin
    // Reset held with tick toggling
    cyc(6);
    chk("rst_ce", 32'(cpu_ce), 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_cnt", 32'(instr_cnt), 0);
    chk("rst_halted", 32'(halted), 0);
    rst_n = 1'b1;
    cyc(3);

    // Free run: 10 enables, two retired instructions, then stop
    base = ce_count;
    press(B_RUN);
    chk("run_mode", 32'(mode), 1);
    wait_ce(base + 10, 300);
    btn_stop = 1'b1;
    cyc(8);
    btn_stop = 1'b0;
    chk("run_cnt", 32'(instr_cnt), 2);
    chk("model_cnt", 32'(m_cnt), 2);
    chk("stop_mode", 32'(mode), 0);
    cyc(40);
    chk("stop_no_ce", 32'(ce_count - base), 10);

    // Five single T-steps complete one instruction
    for (int k = 0; k < 5; k++) begin
      base = ce_count;
      press(B_STEP_T);
      cyc(14);
      chk("step_t_ce", 32'(ce_count - base), 1);
      chk("step_t_mode", 32'(mode), 0);
    end
    chk("step_t_cnt", 32'(instr_cnt), 3);

    // Instruction step: full 5-stage instruction, then an early jump after 3
    base = ce_count;
    press(B_STEP_I);
    cyc(60);
    chk("step_i_ce", 32'(ce_count - base), 5);
    chk("step_i_mode", 32'(mode), 0);
    chk("step_i_cnt", 32'(instr_cnt), 4);
    jump_en = 1'b1;
    base = ce_count;
    press(B_STEP_I);
    cyc(40);
    chk("jump_ce", 32'(ce_count - base), 3);
    chk("jump_cnt", 32'(instr_cnt), 5);
    chk("model_jump_cnt", 32'(m_cnt), 5);
    jump_en = 1'b0;

    // Stop and run together: stop wins
    base = ce_count;
    press(B_STOP | B_RUN);
    cyc(30);
    chk("stop_wins_ce", 32'(ce_count - base), 0);
    chk("stop_wins_mode", 32'(mode), 0);

    // Halt detection and command lock-out
    base = ce_count;
    press(B_RUN);
    wait_ce(base + 2, 100);
    halt_req = 1'b1;
    cyc(4);
    chk("halt_flag", 32'(halted), 1);
    chk("halt_mode", 32'(mode), 4);
    base2 = ce_count;
    press(B_RUN);
    press(B_STEP_T);
    press(B_STEP_I);
    press(B_STOP);
    cyc(30);
    chk("halt_no_ce", 32'(ce_count - base2), 0);
    chk("halt_sticky", 32'(mode), 4);
    rst_n = 1'b0;
    halt_req = 1'b0;
    cyc(2);
    chk("rst2_mode", 32'(mode), 0);
    chk("rst2_cnt", 32'(instr_cnt), 0);
    chk("rst2_ce", 32'(cpu_ce), 0);
    rst_n = 1'b1;
    cyc(3);

    // Breakpoint at pc 4 (fourth retire after reset)
    bp_en = 1'b1;
    base = ce_count;
    bpb = bp_count;
    press(B_RUN);
`ifdef CPU_BREAKPOINT_EN
    n = 0;
    while (!(mode == 3'd0 && ce_count > base) && n < 400) begin
      cyc(1);
      n++;
    end
    cyc(2);
    chk("bp_pulses", 32'(bp_count - bpb), 1);
    chk("bp_ce", 32'(ce_count - base), 20);
    chk("bp_cnt", 32'(instr_cnt), 4);
    chk("bp_mode", 32'(mode), 0);
`else
    wait_ce(base + 25, 400);
    chk("nobp_mode", 32'(mode), 1);
    chk("nobp_pulses", 32'(bp_count - bpb), 0);
`endif

    // Counter saturation at all-ones
    bp_en = 1'b0;
    press(B_RUN);
    wait_ce(base + 90, 1200);
    cyc(2);
    chk("sat_cnt", 32'(instr_cnt), CNT_MAX);
    press(B_STOP);
    cyc(10);
    chk("final_mode", 32'(mode), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
